// File: rtl/sdiv_shift_if.sv
// Request/result bundle for the shift-subtract divider.
// The master drives the operands and go; the slave returns the result, the flags and the status.
interface sdiv_shift_if #(
    parameter int WIDTH = 16
);
    logic             go;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div0;
    logic             ovf;
    logic             busy;
    logic             rdy;

    modport master (
        output go, dividend, divisor,
        input  quotient, remainder, div0, ovf, busy, rdy
    );

    modport slave (
        input  go, dividend, divisor,
        output quotient, remainder, div0, ovf, busy, rdy
    );
endinterface

// File: rtl/sdiv_shift.sv
// Fixed-latency radix-2 restoring divider, signed or unsigned.
// It works on magnitudes and applies the signs in a final FIX cycle.
// The result is valid WIDTH+2 cycles after the accept edge, whatever the operands.
module sdiv_shift #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    sdiv_shift_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] qmag, dmag;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, dz, ov;

    // Operand magnitudes. In WIDTH-bit unsigned, |MIN| is 2^(WIDTH-1) and loses nothing.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = SIGNED && bus.dividend[WIDTH-1];
    assign b_neg = SIGNED && bus.divisor[WIDTH-1];
    assign a_mag = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag = b_neg ? -bus.divisor  : bus.divisor;

    // One restoring step. R stays below Dmag, so the shifted R always fits in WIDTH+1 bits.
    logic [WIDTH:0] r_sh, r_nxt;
    logic           sub_ok;
    assign r_sh   = {r_q[WIDTH-1:0], qmag[WIDTH-1]};
    assign sub_ok = r_sh >= {1'b0, dmag};
    assign r_nxt  = sub_ok ? (r_sh - {1'b0, dmag}) : r_sh;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. go is looked at only in IDLE, so a request during CALC or FIX is dropped.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (bus.go) begin
                accept    = 1'b1;
                state_nxt = CALC;
            end
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift and subtract in CALC, sign-fix and publish in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q           <= '0;
            qmag          <= '0;
            dmag          <= '0;
            cnt           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            dz            <= 1'b0;
            ov            <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.div0      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.rdy       <= 1'b0;
        end else if (accept) begin
            r_q      <= '0;
            qmag     <= a_mag;
            dmag     <= b_mag;
            cnt      <= CW'(WIDTH - 1);
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            dz       <= (bus.divisor == '0);
            ov       <= SIGNED && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
            bus.rdy  <= 1'b0;
            bus.busy <= 1'b1;
        end else if (state == CALC) begin
            r_q  <= r_nxt;
            qmag <= {qmag[WIDTH-2:0], sub_ok};
            cnt  <= cnt - CW'(1);
        end else if (state == FIX) begin
            // With a zero divisor every step subtracts 0. Qmag ends all ones and R ends as |dividend|.
            // The quotient is forced to all ones so that a negative dividend does not flip it to +1.
            bus.quotient  <= dz ? '1 : (neg_q ? -qmag : qmag);
            bus.remainder <= neg_r ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
            bus.div0      <= dz;
            bus.ovf       <= ov;
            bus.rdy       <= 1'b1;
            bus.busy      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sdiv_shift.sv
// Directed bench for sdiv_shift. It drives a signed and an unsigned 16-bit instance through one muxed driver.
module tb_sdiv_shift;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdiv_shift_if #(.WIDTH(16)) if_s ();
    sdiv_shift_if #(.WIDTH(16)) if_u ();

    sdiv_shift #(.WIDTH(16), .SIGNED(1'b1)) u_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
    sdiv_shift #(.WIDTH(16), .SIGNED(1'b0)) u_u (.clk(clk), .rst_n(rst_n), .bus(if_u));

    logic        sel = 1'b0;   // 0 = signed instance, 1 = unsigned instance
    logic        go_v = 1'b0;
    logic [15:0] a_v = '0, b_v = '0;

    assign if_s.go       = go_v & ~sel;
    assign if_u.go       = go_v & sel;
    assign if_s.dividend = a_v;
    assign if_s.divisor  = b_v;
    assign if_u.dividend = a_v;
    assign if_u.divisor  = b_v;

    logic [15:0] q_m, r_m;
    logic        d0_m, ov_m, busy_m, rdy_m;
    assign q_m    = sel ? if_u.quotient  : if_s.quotient;
    assign r_m    = sel ? if_u.remainder : if_s.remainder;
    assign d0_m   = sel ? if_u.div0      : if_s.div0;
    assign ov_m   = sel ? if_u.ovf       : if_s.ovf;
    assign busy_m = sel ? if_u.busy      : if_s.busy;
    assign rdy_m  = sel ? if_u.rdy       : if_s.rdy;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Call at a negedge. The task raises go, counts edges from the accept edge until rdy is seen, then returns at a negedge.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b, output int lat);
        a_v  = a;
        b_v  = b;
        go_v = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        go_v = 1'b0;
        chk("busy_after_accept", 32'(busy_m), 32'd1);
        chk("rdy_clr_after_accept", 32'(rdy_m), 32'd0);
        while (!rdy_m && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        uns;
        logic [15:0] a, b, q, r;
        logic        d0, ov;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int lat;
        vecs[0]  = '{1'b0, 16'd100,   16'd7,    16'd14,   16'd2,    1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'hFF9C,  16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 16'd100,   16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 1'b0};
        vecs[3]  = '{1'b0, 16'hFF9C,  16'hFFF9, 16'd14,   16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h8000,  16'hFFFF, 16'h8000, 16'd0,    1'b0, 1'b1};
        vecs[5]  = '{1'b0, 16'h8000,  16'd1,    16'h8000, 16'd0,    1'b0, 1'b0};
        vecs[6]  = '{1'b0, 16'd1234,  16'd0,    16'hFFFF, 16'd1234, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 16'hFFFB,  16'd0,    16'hFFFF, 16'hFFFB, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 16'd0,     16'd5,    16'd0,    16'd0,    1'b0, 1'b0};
        vecs[9]  = '{1'b0, 16'h7FFF,  16'h8000, 16'd0,    16'h7FFF, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'h8000,  16'h8000, 16'd1,    16'd0,    1'b0, 1'b0};
        vecs[11] = '{1'b0, 16'd7,     16'd100,  16'd0,    16'd7,    1'b0, 1'b0};
        vecs[12] = '{1'b1, 16'hFFFF,  16'd2,    16'h7FFF, 16'd1,    1'b0, 1'b0};
        vecs[13] = '{1'b1, 16'hFFFF,  16'd0,    16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 16'h8000,  16'hFFFF, 16'd0,    16'h8000, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 16'd60000, 16'd7,    16'd8571, 16'd3,    1'b0, 1'b0};

        // Reset state of both instances.
        #1;
        chk("rst_s_q",    32'(if_s.quotient),  32'd0);
        chk("rst_s_r",    32'(if_s.remainder), 32'd0);
        chk("rst_s_flag", 32'({if_s.div0, if_s.ovf, if_s.busy, if_s.rdy}), 32'd0);
        chk("rst_u_flag", 32'({if_u.div0, if_u.ovf, if_u.busy, if_u.rdy}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 16; i++) begin
            sel = vecs[i].uns;
            do_div(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_lat", i),  32'(lat),    32'd18);
            chk($sformatf("v%0d_q", i),    32'(q_m),    32'(vecs[i].q));
            chk($sformatf("v%0d_r", i),    32'(r_m),    32'(vecs[i].r));
            chk($sformatf("v%0d_d0", i),   32'(d0_m),   32'(vecs[i].d0));
            chk($sformatf("v%0d_ov", i),   32'(ov_m),   32'(vecs[i].ov));
            chk($sformatf("v%0d_busy", i), 32'(busy_m), 32'd0);
        end
        sel = 1'b0;

        // A go pulse with new operands in the middle of CALC is dropped and not queued.
        a_v = 16'd100; b_v = 16'd7; go_v = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go_v = 1'b0;
        repeat (5) @(negedge clk);
        a_v = 16'd50; b_v = 16'd3; go_v = 1'b1;
        @(negedge clk);
        go_v = 1'b0; a_v = 16'd9; b_v = 16'd4;
        lat = 0;
        while (!rdy_m && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("midgo_q", 32'(q_m), 32'd14);
        chk("midgo_r", 32'(r_m), 32'd2);
        repeat (4) @(negedge clk);
        chk("midgo_not_queued_rdy",  32'(rdy_m),  32'd1);
        chk("midgo_not_queued_busy", 32'(busy_m), 32'd0);

        // Back-to-back: the second go is accepted on the edge where rdy is first seen.
        do_div(16'd100, 16'd7, lat);
        chk("b2b_1_q", 32'(q_m), 32'd14);
        do_div(16'hFC18, 16'd33, lat);
        chk("b2b_2_lat", 32'(lat), 32'd18);
        chk("b2b_2_q",   32'(q_m), 32'hFFE2);
        chk("b2b_2_r",   32'(r_m), 32'hFFF6);

        // Reset at cycle 9 of a divide. All outputs must clear at once.
        a_v = 16'hFF9C; b_v = 16'd7; go_v = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go_v = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_q",     32'(if_s.quotient),  32'd0);
        chk("midrst_r",     32'(if_s.remainder), 32'd0);
        chk("midrst_flags", 32'({if_s.div0, if_s.ovf, if_s.busy, if_s.rdy}), 32'd0);
        chk("midrst_state", 32'(u_s.state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_div(16'hFF9C, 16'd7, lat);
        chk("postrst_lat", 32'(lat), 32'd18);
        chk("postrst_q",   32'(q_m), 32'hFFF2);
        chk("postrst_r",   32'(r_m), 32'hFFFE);

        // Random signed sweep against a truncating reference model.
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] a, b, eq, er;
            logic        ed0, eov;
            int          ai, bi;
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 9)) : 16'($urandom);
            if (n == 0) a = 16'h8000;
            if (n == 0) b = 16'hFFFF;
            ai = int'($signed(a));
            bi = int'($signed(b));
            ed0 = 1'b0; eov = 1'b0;
            if (bi == 0) begin
                eq = 16'hFFFF; er = a; ed0 = 1'b1;
            end else if (ai == -32768 && bi == -1) begin
                eq = 16'h8000; er = 16'd0; eov = 1'b1;
            end else begin
                eq = 16'(ai / bi); er = 16'(ai % bi);
            end
            do_div(a, b, lat);
            chk("rnd_q", 32'(q_m), 32'(eq));
            chk("rnd_r", 32'(r_m), 32'(er));
            chk("rnd_flags", 32'({d0_m, ov_m}), 32'({ed0, eov}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
